// File: rtl/ahb_arbiter_param.sv
// ahb_arbiter_param
// -----------------------------------------------------------------------------
// Parametrised AHB bus arbiter. Picks one of NUM_MASTERS requesters, drives a
// registered one-hot HGRANT and tracks the address-phase owner (HMASTER,
// HMASTLOCK) for the address/data muxes and the slaves.
//
// Grant policy: fixed priority (ARB_MODE=0, index 0 highest) or round robin
// (ARB_MODE=1, scan upward from the last granted requester). With no requests
// the bus parks on DEFAULT_MASTER. The grant is held across locked transfers
// and across the remaining beats of fixed-length (4/8/16 beat) bursts.
//
// Ports
//   HCLK       in   bus clock, rising edge
//   HRESET     in   synchronous active-high reset
//   HBUSREQ    in   [NUM_MASTERS] per-master bus request
//   HLOCK      in   [NUM_MASTERS] per-master lock request
//   HTRANS     in   [2] transfer type of current address owner
//   HBURST     in   [3] burst type of current address owner
//   HREADY     in   bus-wide ready
//   HRESP      in   [2] transfer response
//   HGRANT     out  [NUM_MASTERS] one-hot grant (registered)
//   HMASTER    out  [MW] address-phase owner index (registered)
//   HMASTLOCK  out  address phase is locked (registered)
// -----------------------------------------------------------------------------
module ahb_arbiter_param #(
  parameter int NUM_MASTERS    = 4,
  parameter int ARB_MODE       = 0,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [1:0] RSP_OKAY  = 2'b00;

  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] GRANT_RST =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_MASTERS-1:0] grant_q,    grant_d;
  logic [MW-1:0]          master_q,   master_d;
  logic                   mastlock_q, mastlock_d;
  logic [3:0]             cnt_q,      cnt_d;     // remaining protected beats
  logic [MW-1:0]          rr_ptr_q,   rr_ptr_d;  // last requester granted

  // ---------------------------------------------------------------------------
  // Current owner index from the one-hot grant
  // ---------------------------------------------------------------------------
  logic [MW-1:0] owner_idx;

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) owner_idx = MW'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Burst beat counter. A NONSEQ of a fixed-length burst loads beats-1, each
  // accepted SEQ counts down. Any non-OKAY response with HREADY kills the
  // burst so the arbiter can hand the bus over at that same edge. SINGLE and
  // INCR never load, so undefined-length bursts are not protected.
  // ---------------------------------------------------------------------------
  logic [3:0] burst_load;

  always_comb begin
    burst_load = 4'd0;
    unique case (HBURST)
      3'b010, 3'b011: burst_load = 4'd3;
      3'b100, 3'b101: burst_load = 4'd7;
      3'b110, 3'b111: burst_load = 4'd15;
      default:        burst_load = 4'd0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (HREADY) begin
      if (HRESP != RSP_OKAY) begin
        cnt_d = 4'd0;
      end else begin
        unique case (HTRANS)
          TR_NONSEQ: cnt_d = burst_load;
          TR_SEQ:    cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
          TR_IDLE:   cnt_d = 4'd0;
          TR_BUSY:   cnt_d = cnt_q;
          default:   cnt_d = cnt_q;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hold / re-arbitration decision. Looking at cnt_d (not cnt_q) releases the
  // grant on the edge that accepts the final address of a burst.
  // ---------------------------------------------------------------------------
  logic hold;
  logic rearb;

  assign hold  = HLOCK[owner_idx] | (cnt_d != 4'd0);
  assign rearb = HREADY & ~hold;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
  logic [MW-1:0] fp_idx;
  logic [MW-1:0] rr_idx;
  logic [MW-1:0] scan_idx;
  logic          rr_found;
  logic          any_req;
  logic [MW-1:0] winner;

  assign any_req = |HBUSREQ;

  // Fixed priority: lowest set index wins (scan downward, last hit sticks).
  always_comb begin
    fp_idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (HBUSREQ[i]) fp_idx = MW'(i);
    end
  end

  // Round robin: first requester scanning upward from rr_ptr+1, wrapping.
  // The current owner competes at position rr_ptr+NUM_MASTERS, i.e. last.
  always_comb begin
    rr_idx   = rr_ptr_q;
    rr_found = 1'b0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      scan_idx = MW'((int'(rr_ptr_q) + k) % NUM_MASTERS);
      if (!rr_found && HBUSREQ[scan_idx]) begin
        rr_idx   = scan_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    winner = DEF_IDX;
    if (any_req) winner = (ARB_MODE == 1) ? rr_idx : fp_idx;
  end

  // ---------------------------------------------------------------------------
  // Next-state for grant, pointer and address-phase ownership
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    master_d   = master_q;
    mastlock_d = mastlock_q;

    if (rearb) begin
      grant_d         = '0;
      grant_d[winner] = 1'b1;
      // Parking on the default master is not a real grant for fairness.
      if (any_req) rr_ptr_d = winner;
    end

    // The granted master owns the next address phase once HREADY completes
    // the current one.
    if (HREADY) begin
      master_d   = owner_idx;
      mastlock_d = HLOCK[owner_idx];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_q    <= GRANT_RST;
      master_q   <= DEF_IDX;
      mastlock_q <= 1'b0;
      cnt_q      <= 4'd0;
      rr_ptr_q   <= DEF_IDX;
    end else begin
      grant_q    <= grant_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// Bench for ahb_arbiter_param. Two instances share one stimulus stream:
//   dut0: fixed priority, parks on master 2
//   dut1: round robin,    parks on master 0
// A cycle-level reference model (integers, modulo scan) tracks both.
module tb_ahb_arbiter_param;
  localparam int N = 4;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [N-1:0]  HBUSREQ, HLOCK;
  logic [1:0]    HTRANS;
  logic [2:0]    HBURST;
  logic          HREADY;
  logic [1:0]    HRESP;
  logic [N-1:0]  g0, g1;
  logic [1:0]    m0, m1;
  logic          l0, l1;

  always #5 HCLK = ~HCLK;

  ahb_arbiter_param #(.NUM_MASTERS(N), .ARB_MODE(0), .DEFAULT_MASTER(2)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
    .HGRANT(g0), .HMASTER(m0), .HMASTLOCK(l0));

  ahb_arbiter_param #(.NUM_MASTERS(N), .ARB_MODE(1), .DEFAULT_MASTER(0)) dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
    .HGRANT(g1), .HMASTER(m1), .HMASTLOCK(l1));

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state, per configuration
  int cfg_def[2]  = '{2, 0};
  int cfg_mode[2] = '{0, 1};
  int m_own[2], m_mst[2], m_lck[2], m_cnt[2], m_rr[2];

  task automatic drive(input logic [3:0] req, input logic [3:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu,
                       input logic rdy, input logic [1:0] rsp);
    HBUSREQ = req; HLOCK = lck; HTRANS = tr; HBURST = bu;
    HREADY = rdy; HRESP = rsp;
  endtask

  // Advance model and clock by one edge; outputs are settled 1 time unit later.
  task automatic tick();
    int nx_own[2], nx_mst[2], nx_lck[2], nx_cnt[2], nx_rr[2];
    for (int c = 0; c < 2; c++) begin
      int own, cn, win, rr;
      bit hold;
      own = m_own[c];
      if (!HREADY)             cn = m_cnt[c];
      else if (HRESP != 2'b00) cn = 0;
      else begin
        case (HTRANS)
          2'b00:   cn = 0;
          2'b01:   cn = m_cnt[c];
          2'b10:   cn = (HBURST >= 3'd2) ? (2 << (HBURST >> 1)) - 1 : 0;
          default: cn = (m_cnt[c] > 0) ? m_cnt[c] - 1 : 0;
        endcase
      end
      hold = HLOCK[2'(own)] || (cn != 0);
      win = own; rr = m_rr[c];
      if (HREADY && !hold) begin
        if (HBUSREQ == '0) win = cfg_def[c];
        else if (cfg_mode[c] == 0) begin
          for (int i = N - 1; i >= 0; i--) if (HBUSREQ[i]) win = i;
        end else begin
          for (int k = N; k >= 1; k--)
            if (HBUSREQ[2'((m_rr[c] + k) % N)]) win = (m_rr[c] + k) % N;
          rr = win;
        end
      end
      nx_own[c] = win; nx_rr[c] = rr; nx_cnt[c] = cn;
      nx_mst[c] = HREADY ? own : m_mst[c];
      nx_lck[c] = HREADY ? int'(HLOCK[2'(own)]) : m_lck[c];
      if (HRESET) begin
        nx_own[c] = cfg_def[c]; nx_mst[c] = cfg_def[c]; nx_lck[c] = 0;
        nx_cnt[c] = 0; nx_rr[c] = cfg_def[c];
      end
    end
    @(posedge HCLK);
    m_own = nx_own; m_mst = nx_mst; m_lck = nx_lck; m_cnt = nx_cnt; m_rr = nx_rr;
    #1;
  endtask

  task automatic reset_bus();
    HRESET = 1'b1; drive(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    tick();
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    drive(4'b1111, 4'b0000, 2'b10, 3'b011, 1'b1, 2'b00);
    tick(); tick(); tick();
    HRESET = 1'b1;
    tick();
    n_chk++; if (g0 !== 4'b0100) $display("FAIL rst_grant0 got %b want 0100", g0); else n_pass++;
    n_chk++; if (m0 !== 2'd2) $display("FAIL rst_master0 got %0d want 2", m0); else n_pass++;
    n_chk++; if (l0 !== 1'b0) $display("FAIL rst_lock0 got %b want 0", l0); else n_pass++;
    n_chk++; if (g1 !== 4'b0001) $display("FAIL rst_grant1 got %b want 0001", g1); else n_pass++;
    tick();
    n_chk++; if (g0 !== 4'b0100) $display("FAIL rst_held got %b want 0100", g0); else n_pass++;
    HRESET = 1'b0;
    drive(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if (g0 !== 4'b0100 || m0 !== 2'd2)
        $display("FAIL park cyc%0d got grant %b master %0d want 0100/2", i, g0, m0);
      else n_pass++;
    end
  endtask

  task automatic test_fixed_prio();
    reset_bus();
    drive(4'b1010, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    tick();
    n_chk++; if (g0 !== 4'b0010) $display("FAIL fp_grant got %b want 0010", g0); else n_pass++;
    HBUSREQ = 4'b1000;
    tick();
    n_chk++; if (g0 !== 4'b1000) $display("FAIL fp_regrant got %b want 1000", g0); else n_pass++;
    n_chk++; if (m0 !== 2'd1) $display("FAIL fp_master_old got %0d want 1", m0); else n_pass++;
    tick();
    n_chk++; if (m0 !== 2'd3) $display("FAIL fp_master_new got %0d want 3", m0); else n_pass++;
  endtask

  task automatic test_round_robin();
    int seq[6] = '{1, 2, 3, 0, 1, 2};
    logic [3:0] eg;
    reset_bus();
    drive(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    for (int i = 0; i < 6; i++) begin
      tick();
      eg = '0; eg[2'(seq[i])] = 1'b1;
      n_chk++;
      if (g1 !== eg) $display("FAIL rr_seq%0d got %b want %b", i, g1, eg); else n_pass++;
    end
    HBUSREQ = 4'b0101;
    tick();
    n_chk++; if (g1 !== 4'b0001) $display("FAIL rr_skip got %b want 0001", g1); else n_pass++;
  endtask

  task automatic test_burst();
    reset_bus();
    drive(4'b0001, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    tick();
    HBUSREQ = 4'b0010; HTRANS = 2'b10; HBURST = 3'b011;   // NONSEQ INCR4
    tick();
    n_chk++; if (g0 !== 4'b0001) $display("FAIL bu_beat1 got %b want 0001", g0); else n_pass++;
    HTRANS = 2'b11; HREADY = 1'b0;                        // beat 2 stalled
    tick();
    n_chk++; if (g0 !== 4'b0001) $display("FAIL bu_stall got %b want 0001", g0); else n_pass++;
    HREADY = 1'b1;
    tick();
    n_chk++; if (g0 !== 4'b0001) $display("FAIL bu_beat2 got %b want 0001", g0); else n_pass++;
    tick();
    n_chk++; if (g0 !== 4'b0001) $display("FAIL bu_beat3 got %b want 0001", g0); else n_pass++;
    tick();
    n_chk++; if (g0 !== 4'b0010) $display("FAIL bu_beat4 got %b want 0010", g0); else n_pass++;
    n_chk++; if (m0 !== 2'd0) $display("FAIL bu_master_last got %0d want 0", m0); else n_pass++;
    HTRANS = 2'b00;
    tick();
    n_chk++; if (m0 !== 2'd1) $display("FAIL bu_master_new got %0d want 1", m0); else n_pass++;
  endtask

  task automatic test_early_term();
    reset_bus();
    drive(4'b0001, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    tick();
    HBUSREQ = 4'b0010; HTRANS = 2'b10; HBURST = 3'b011;
    tick();
    n_chk++; if (g0 !== 4'b0001) $display("FAIL et_beat1 got %b want 0001", g0); else n_pass++;
    HTRANS = 2'b11; HRESP = 2'b01;
    tick();
    n_chk++; if (g0 !== 4'b0010) $display("FAIL et_error got %b want 0010", g0); else n_pass++;
    HRESP = 2'b00; HTRANS = 2'b00;
  endtask

  task automatic test_lock();
    reset_bus();
    drive(4'b1000, 4'b1000, 2'b00, 3'b000, 1'b1, 2'b00);
    tick();
    n_chk++; if (g0 !== 4'b1000) $display("FAIL lk_grant got %b want 1000", g0); else n_pass++;
    HBUSREQ = 4'b1001;
    tick();
    n_chk++; if (g0 !== 4'b1000) $display("FAIL lk_hold got %b want 1000", g0); else n_pass++;
    n_chk++; if (l0 !== 1'b1) $display("FAIL lk_mastlock got %b want 1", l0); else n_pass++;
    HBUSREQ = 4'b0001;                                   // owner drops request
    tick();
    n_chk++; if (g0 !== 4'b1000) $display("FAIL lk_noreq got %b want 1000", g0); else n_pass++;
    HLOCK = 4'b0000;
    tick();
    n_chk++; if (g0 !== 4'b0001) $display("FAIL lk_release got %b want 0001", g0); else n_pass++;
    tick();
    n_chk++; if (l0 !== 1'b0 || m0 !== 2'd0)
      $display("FAIL lk_after got lock %b master %0d want 0/0", l0, m0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] eg0, eg1;
    for (int i = 0; i < 400; i++) begin
      HBUSREQ = 4'($urandom);
      HLOCK   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      HTRANS  = 2'($urandom);
      HBURST  = 3'($urandom);
      HREADY  = ($urandom_range(0, 3) != 0);
      HRESP   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      HRESET  = ($urandom_range(0, 99) == 0);
      tick();
      eg0 = '0; eg0[2'(m_own[0])] = 1'b1;
      eg1 = '0; eg1[2'(m_own[1])] = 1'b1;
      n_chk++; if (g0 !== eg0) $display("FAIL rnd%0d grant0 got %b want %b", i, g0, eg0); else n_pass++;
      n_chk++; if (g1 !== eg1) $display("FAIL rnd%0d grant1 got %b want %b", i, g1, eg1); else n_pass++;
      n_chk++; if (m0 !== 2'(m_mst[0])) $display("FAIL rnd%0d master0 got %0d want %0d", i, m0, m_mst[0]); else n_pass++;
      n_chk++; if (m1 !== 2'(m_mst[1])) $display("FAIL rnd%0d master1 got %0d want %0d", i, m1, m_mst[1]); else n_pass++;
      n_chk++; if (l0 !== 1'(m_lck[0])) $display("FAIL rnd%0d lock0 got %b want %0d", i, l0, m_lck[0]); else n_pass++;
      n_chk++; if (l1 !== 1'(m_lck[1])) $display("FAIL rnd%0d lock1 got %b want %0d", i, l1, m_lck[1]); else n_pass++;
    end
    HRESET = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1;
    drive(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    tick(); tick();
    HRESET = 1'b0;
    test_reset();
    test_fixed_prio();
    test_round_robin();
    test_burst();
    test_early_term();
    test_lock();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
